// File: rtl/debug_dump_sender.sv
// Read-side sequencer for the pipeline snapshot store: captures one snapshot, walks the
// read codes and streams every returned word to the UART transmitter MSB byte first.
module debug_dump_sender #(
   parameter int CANT_BITS_CONTROL    = 4,
   parameter int LONGITUD_INSTRUCCION = 32,
   parameter int WIDTH_WORD_TX        = 8,
   parameter int PRIMER_CODIGO        = 2,
   parameter int ULTIMO_CODIGO        = 11
) (
   input  logic                            i_clock,
   input  logic                            i_soft_reset,
   input  logic                            i_start,
   input  logic [LONGITUD_INSTRUCCION-1:0] i_dato,
   output logic [CANT_BITS_CONTROL-1:0]    o_control,
   output logic [WIDTH_WORD_TX-1:0]        o_tx_data,
   output logic                            o_tx_start,
   input  logic                            i_tx_done,
   output logic                            o_busy,
   output logic                            o_done
);

   localparam logic [CANT_BITS_CONTROL-1:0] CODE_FIRST   = CANT_BITS_CONTROL'(PRIMER_CODIGO);
   localparam logic [CANT_BITS_CONTROL-1:0] CODE_LAST    = CANT_BITS_CONTROL'(ULTIMO_CODIGO);
   localparam logic [CANT_BITS_CONTROL-1:0] CODE_STEP    = CANT_BITS_CONTROL'(1);
   localparam logic [CANT_BITS_CONTROL-1:0] CTRL_HOLD    = '0;
   localparam logic [CANT_BITS_CONTROL-1:0] CTRL_CAPTURE = CANT_BITS_CONTROL'(1);
   localparam logic [1:0] LAST_BYTE = 2'(LONGITUD_INSTRUCCION / WIDTH_WORD_TX - 1);

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      SELECT,
      LATCH,
      SEND,
      WAIT_TX,
      DONE
   } state_t;

   state_t                            state_q, state_d;
   logic [CANT_BITS_CONTROL-1:0]      code_q, code_d;
   logic [1:0]                        idx_q, idx_d;
   logic [LONGITUD_INSTRUCCION-1:0]   shift_q, shift_d;
   logic [LONGITUD_INSTRUCCION-1:0]   shift_next_byte;
   logic [CANT_BITS_CONTROL-1:0]      control_d;
   logic [WIDTH_WORD_TX-1:0]          tx_data_d;
   logic                              tx_start_d;
   logic                              busy_d;
   logic                              done_d;

   assign shift_next_byte = shift_q << WIDTH_WORD_TX;

   // Outputs are computed for the state being entered, so each one is a plain flop.
   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      control_d  = CTRL_HOLD;
      tx_data_d  = o_tx_data;
      tx_start_d = 1'b0;
      busy_d     = o_busy;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d   = CAPTURE;
               control_d = CTRL_CAPTURE;
               busy_d    = 1'b1;
            end
         end

         CAPTURE: begin
            state_d   = SELECT;
            control_d = code_q;
         end

         SELECT: begin
            state_d = LATCH;
         end

         // The store registered the selected word on the SELECT edge, so i_dato is valid now.
         LATCH: begin
            shift_d    = i_dato;
            idx_d      = 2'd0;
            state_d    = SEND;
            tx_data_d  = i_dato[LONGITUD_INSTRUCCION-1 -: WIDTH_WORD_TX];
            tx_start_d = 1'b1;
         end

         SEND: begin
            state_d = WAIT_TX;
         end

         WAIT_TX: begin
            if (i_tx_done) begin
               if (idx_q != LAST_BYTE) begin
                  shift_d    = shift_next_byte;
                  idx_d      = idx_q + 2'd1;
                  state_d    = SEND;
                  tx_data_d  = shift_next_byte[LONGITUD_INSTRUCCION-1 -: WIDTH_WORD_TX];
                  tx_start_d = 1'b1;
               end else if (code_q < CODE_LAST) begin
                  code_d    = code_q + CODE_STEP;
                  state_d   = SELECT;
                  control_d = code_q + CODE_STEP;
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end
            end
         end

         DONE: begin
            code_d  = CODE_FIRST;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clock or negedge i_soft_reset) begin
      if (!i_soft_reset) begin
         state_q    <= IDLE;
         code_q     <= CODE_FIRST;
         idx_q      <= 2'd0;
         shift_q    <= '0;
         o_control  <= CTRL_HOLD;
         o_tx_data  <= '0;
         o_tx_start <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         o_control  <= control_d;
         o_tx_data  <= tx_data_d;
         o_tx_start <= tx_start_d;
         o_busy     <= busy_d;
         o_done     <= done_d;
      end
   end

endmodule

// File: tb/tb_debug_dump_sender.sv
// Directed bench for debug_dump_sender with a register model of the snapshot store.
module tb_debug_dump_sender;

   logic        i_clock = 1'b0;
   logic        i_soft_reset = 1'b0;
   logic        i_start = 1'b0;
   logic [31:0] i_dato = 32'h0;
   logic [3:0]  o_control;
   logic [7:0]  o_tx_data;
   logic        o_tx_start;
   logic        i_tx_done = 1'b0;
   logic        o_busy;
   logic        o_done;

   int n_checks = 0;
   int n_pass   = 0;
   int n_starts = 0;
   int n_dones  = 0;
   int store_mode = 0;

   debug_dump_sender dut (
      .i_clock      (i_clock),
      .i_soft_reset (i_soft_reset),
      .i_start      (i_start),
      .i_dato       (i_dato),
      .o_control    (o_control),
      .o_tx_data    (o_tx_data),
      .o_tx_start   (o_tx_start),
      .i_tx_done    (i_tx_done),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   always #5 i_clock = ~i_clock;

   function automatic logic [31:0] store_word(input logic [3:0] c, input int mode);
      if (mode == 0) return (c == 4'd2) ? 32'hA1B2C3D4 : 32'hE0E1E2E3;
      return {28'h0, c};
   endfunction

   // Snapshot store: registers the word for a read code on the edge it is selected
   always @(posedge i_clock)
      if (o_control >= 4'd2 && o_control <= 4'd11) i_dato <= store_word(o_control, store_mode);

   always @(negedge i_clock) begin
      if (o_tx_start) n_starts <= n_starts + 1;
      if (o_done)     n_dones  <= n_dones + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   task automatic do_reset();
      i_start      = 1'b0;
      i_tx_done    = 1'b0;
      i_soft_reset = 1'b0;
      #2;
      i_soft_reset = 1'b1;
      tick();
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (o_tx_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic ack_after_3();
      tick();
      tick();
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      n_checks++;
      if ({o_control, o_tx_data, o_tx_start, o_busy, o_done} !== 15'h0)
         $display("FAIL reset_outputs: got ctrl=%0d data=%h start=%b busy=%b done=%b, want all 0",
                  o_control, o_tx_data, o_tx_start, o_busy, o_done);
      else n_pass++;
      i_soft_reset = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         n_checks++;
         if ({o_control, o_tx_start, o_busy, o_done} !== 7'h0)
            $display("FAIL idle_quiet cycle %0d: got ctrl=%0d start=%b busy=%b done=%b, want 0",
                     c, o_control, o_tx_start, o_busy, o_done);
         else n_pass++;
      end
   endtask

   task automatic test_single_word();
      logic [7:0] exp_b [3] = '{8'hB2, 8'hC3, 8'hD4};
      store_mode = 0;
      pulse_start();
      n_checks++;
      if ({o_control, o_busy} !== {4'd1, 1'b1})
         $display("FAIL capture_cycle: got ctrl=%0d busy=%b, want ctrl=1 busy=1", o_control, o_busy);
      else n_pass++;
      tick();
      n_checks++;
      if (o_control !== 4'd2) $display("FAIL select_cycle: got ctrl=%0d, want 2", o_control);
      else n_pass++;
      tick();
      n_checks++;
      if ({o_control, o_tx_start} !== {4'd0, 1'b0})
         $display("FAIL latch_cycle: got ctrl=%0d start=%b, want 0 0", o_control, o_tx_start);
      else n_pass++;
      tick();
      n_checks++;
      if ({o_tx_start, o_tx_data} !== {1'b1, 8'hA1})
         $display("FAIL first_byte_latency: got start=%b data=%h, want 1 a1", o_tx_start, o_tx_data);
      else n_pass++;
      for (int b = 0; b < 3; b++) begin
         tick();
         i_tx_done = 1'b1;
         tick();
         i_tx_done = 1'b0;
         n_checks++;
         if ({o_tx_start, o_tx_data} !== {1'b1, exp_b[b]})
            $display("FAIL word_byte %0d: got start=%b data=%h, want 1 %h", b + 1, o_tx_start, o_tx_data, exp_b[b]);
         else n_pass++;
      end
      tick();
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
      n_checks++;
      if (o_control !== 4'd3) $display("FAIL next_code: got ctrl=%0d, want 3", o_control);
      else n_pass++;
      do_reset();
   endtask

   task automatic test_full_dump();
      int  base_s;
      int  base_d;
      bit  ok;
      bit  was_busy;
      logic [7:0] exp;
      store_mode = 1;
      base_s = n_starts;
      base_d = n_dones;
      was_busy = 1'b0;
      pulse_start();
      for (int i = 0; i < 40; i++) begin
         wait_start(ok);
         n_checks++;
         if (!ok) begin
            $display("FAIL dump_start_timeout byte %0d: got no o_tx_start, want a pulse", i);
            break;
         end
         n_pass++;
         exp = (i % 4 == 3) ? 8'(2 + i / 4) : 8'h00;
         n_checks++;
         if (o_tx_data !== exp) $display("FAIL dump_byte %0d: got %h, want %h", i, o_tx_data, exp);
         else n_pass++;
         tick();
         tick();
         i_tx_done = 1'b1;
         was_busy = o_busy;
         tick();
         i_tx_done = 1'b0;
      end
      n_checks++;
      if ({o_done, o_busy, was_busy} !== 3'b101)
         $display("FAIL dump_done: got done=%b busy=%b prev_busy=%b, want 1 0 1", o_done, o_busy, was_busy);
      else n_pass++;
      repeat (5) tick();
      n_checks++;
      if (n_starts - base_s !== 40) $display("FAIL dump_start_count: got %0d, want 40", n_starts - base_s);
      else n_pass++;
      n_checks++;
      if (n_dones - base_d !== 1) $display("FAIL dump_done_count: got %0d, want 1", n_dones - base_d);
      else n_pass++;
   endtask

   task automatic test_busy_ignore();
      store_mode = 0;
      pulse_start();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      n_checks++;
      if (o_control !== 4'd2) $display("FAIL busy_restart: got ctrl=%0d, want 2", o_control);
      else n_pass++;
      tick();
      tick();
      n_checks++;
      if ({o_tx_start, o_tx_data} !== {1'b1, 8'hA1})
         $display("FAIL busy_first_byte: got start=%b data=%h, want 1 a1", o_tx_start, o_tx_data);
      else n_pass++;
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         n_checks++;
         if ({o_tx_start, o_tx_data, o_control} !== {1'b0, 8'hA1, 4'd0})
            $display("FAIL stray_done cycle %0d: got start=%b data=%h ctrl=%0d, want 0 a1 0",
                     c, o_tx_start, o_tx_data, o_control);
         else n_pass++;
         tick();
      end
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
      n_checks++;
      if ({o_tx_start, o_tx_data} !== {1'b1, 8'hB2})
         $display("FAIL after_stray_byte: got start=%b data=%h, want 1 b2", o_tx_start, o_tx_data);
      else n_pass++;
      do_reset();
   endtask

   task automatic test_reset_mid();
      int base_d;
      bit ok;
      store_mode = 1;
      base_d = n_dones;
      pulse_start();
      for (int i = 0; i < 17; i++) begin
         wait_start(ok);
         if (!ok) break;
         if (i < 16) ack_after_3();
      end
      n_checks++;
      if ({ok, o_tx_data, o_busy} !== {1'b1, 8'h00, 1'b1})
         $display("FAIL code6_reached: got ok=%b data=%h busy=%b, want 1 00 1", ok, o_tx_data, o_busy);
      else n_pass++;
      tick();
      i_soft_reset = 1'b0;
      #2;
      n_checks++;
      if ({o_control, o_tx_data, o_tx_start, o_busy, o_done} !== 15'h0)
         $display("FAIL async_abort: got ctrl=%0d data=%h start=%b busy=%b done=%b, want all 0",
                  o_control, o_tx_data, o_tx_start, o_busy, o_done);
      else n_pass++;
      tick();
      i_soft_reset = 1'b1;
      repeat (5) tick();
      n_checks++;
      if (n_dones !== base_d || {o_busy, o_tx_start, o_done} !== 3'b000)
         $display("FAIL abort_no_done: got dones=%0d busy=%b start=%b, want dones=%0d busy=0 start=0",
                  n_dones, o_busy, o_tx_start, base_d);
      else n_pass++;
      pulse_start();
      n_checks++;
      if (o_control !== 4'd1) $display("FAIL restart_capture: got ctrl=%0d, want 1", o_control);
      else n_pass++;
      tick();
      n_checks++;
      if (o_control !== 4'd2) $display("FAIL restart_code: got ctrl=%0d, want 2", o_control);
      else n_pass++;
      do_reset();
   endtask

   task automatic test_hold_off();
      bit ok;
      int bad;
      store_mode = 0;
      bad = 0;
      pulse_start();
      wait_start(ok);
      n_checks++;
      if ({ok, o_tx_data} !== {1'b1, 8'hA1})
         $display("FAIL holdoff_first: got ok=%b data=%h, want 1 a1", ok, o_tx_data);
      else n_pass++;
      repeat (1000) begin
         tick();
         if ({o_tx_start, o_tx_data, o_control, o_busy} !== {1'b0, 8'hA1, 4'd0, 1'b1}) bad++;
      end
      n_checks++;
      if (bad !== 0) $display("FAIL holdoff_stable: got %0d bad cycles, want 0", bad);
      else n_pass++;
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
      n_checks++;
      if ({o_tx_start, o_tx_data} !== {1'b1, 8'hB2})
         $display("FAIL holdoff_resume: got start=%b data=%h, want 1 b2", o_tx_start, o_tx_data);
      else n_pass++;
      do_reset();
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_full_dump();
      test_busy_ignore();
      test_reset_mid();
      test_hold_off();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/debug_dump_sender.md
Name: debug_dump_sender

Overview:
Sequencer that drives the pipeline snapshot store's 4-bit command input and reads back its 32-bit data word. On request it captures one snapshot, then walks read codes 2..11. Each returned word is split into four bytes, MSB first, and handed to the UART transmitter with a start/done handshake. It sits between the debug-unit top FSM and the UART TX: the read side of the snapshot store.

Parameters:
CANT_BITS_CONTROL, 4, width of command bus to snapshot store
LONGITUD_INSTRUCCION, 32, width of snapshot data word
WIDTH_WORD_TX, 8, UART byte width
PRIMER_CODIGO, 2, first read code walked
ULTIMO_CODIGO, 11, last read code walked (inclusive)

Ports:
i_clock  in  1  system clock, rising edge
i_soft_reset  in  1  reset, asynchronous, active-low
i_start  in  1  one-cycle request to capture and dump a snapshot
i_dato  in  LONGITUD_INSTRUCCION  data word returned by snapshot store
o_control  out  CANT_BITS_CONTROL  command to snapshot store (0=hold, 1=capture, 2..11=read)
o_tx_data  out  WIDTH_WORD_TX  byte to UART TX
o_tx_start  out  1  one-cycle pulse, o_tx_data valid
i_tx_done  in  1  one-cycle pulse from UART TX, byte finished
o_busy  out  1  high from accept of i_start until return to IDLE
o_done  out  1  one-cycle pulse after last byte acknowledged

Behaviour:
- Reset (async, i_soft_reset=0): state IDLE; o_control=0, o_tx_data=0, o_tx_start=0, o_busy=0, o_done=0; code counter=PRIMER_CODIGO; byte index=0; shift register=0.
- All outputs are registered. o_control is 0 in every state except CAPTURE and SELECT. Codes 0 and 12..15 are never driven as read codes; 12..15 clear the store.
- States:
  - IDLE: if i_start=1, go to CAPTURE with o_busy=1. Otherwise remain.
  - CAPTURE (1 cycle): o_control=1. Go to SELECT.
  - SELECT (1 cycle): o_control=code. Go to LATCH.
  - LATCH (1 cycle): o_control=0. i_dato is valid because the store registers its output on the SELECT edge. Load i_dato into the shift register, set byte index=0, go to SEND.
  - SEND (1 cycle): o_tx_data=shift[31:24]; o_tx_start=1. Go to WAIT_TX.
  - WAIT_TX: o_tx_start=0 and o_tx_data held. On i_tx_done=1:
    - if byte index<3: shift left by 8, index+1, go to SEND.
    - else if code<ULTIMO_CODIGO: code+1, go to SELECT.
    - else: go to DONE.
  - DONE (1 cycle): o_done=1, o_busy=0 at next edge, code reset to PRIMER_CODIGO, go to IDLE.
- i_start is ignored in every state except IDLE.
- i_tx_done is sampled only in WAIT_TX. A done pulse arriving in the same cycle as o_tx_start is ignored.
- Latency, i_start to first o_tx_start: 4 cycles (CAPTURE, SELECT, LATCH, SEND).
- A full dump is 10 words = 40 bytes and 40 start/done handshakes.
- Byte order within a word: [31:24], [23:16], [15:8], [7:0].
- Reset mid-dump aborts immediately to IDLE. No o_done is issued. The partial byte in flight at the UART is not recalled.
- Counter widths: code counter CANT_BITS_CONTROL bits; byte index 2 bits. No wrap occurs because the range is bounded by ULTIMO_CODIGO.

Test Plan:
- Reset release, no stimulus:
  - o_control=0, o_tx_start=0, o_busy=0 held for 20 cycles.
- i_start pulse, store model returns word 0xA1B2C3D4 for code 2:
  - o_control sequence 1, 2, 0 on consecutive cycles.
  - First o_tx_start 4 cycles after i_start with o_tx_data=0xA1.
  - After successive i_tx_done pulses: 0xB2, 0xC3, 0xD4.
- Full dump, store returns 0x000000NN for code NN, i_tx_done 3 cycles after each start:
  - Exactly 40 o_tx_start pulses.
  - Every 4th byte equals 0x02..0x0B in order.
  - One o_done pulse, o_busy falls with it.
- i_start pulsed while busy, plus i_tx_done pulsed in a SEND cycle:
  - No restart; byte stream unchanged.
  - Stray done ignored: next byte only after a done in WAIT_TX.
- i_soft_reset asserted during the byte for code 6:
  - All outputs 0 asynchronously, no o_done.
  - Next i_start restarts at o_control=1 then code 2.
- i_tx_done held off for 1000 cycles:
  - FSM stays in WAIT_TX, o_tx_data stable, o_control=0 throughout.
